// File: rtl/als_level_averager_if.sv
// Bus bundle between the ALS SPI receiver frame, the averager and the LED bar pins.
// The averager sits on the slave side; whoever feeds frames and reads the bar uses master.
interface als_level_averager_if;
  logic [15:0] value;
  logic        hold;
  logic [7:0]  avg;
  logic        avg_valid;
  logic [7:0]  level;

  modport master (
    output value,
    output hold,
    input  avg,
    input  avg_valid,
    input  level
  );

  modport slave (
    input  value,
    input  hold,
    output avg,
    output avg_valid,
    output level
  );
endinterface

// File: rtl/als_level_averager.sv
// Samples the 8-bit ALS ADC field at a fixed rate, keeps a running-sum moving average
// over 2^LOG2_DEPTH samples and drives an 8-LED thermometer bar with hysteresis.
module als_level_averager #(
  parameter int CLK_HZ     = 12000000,
  parameter int SAMPLE_HZ  = 100,
  parameter int LOG2_DEPTH = 3,
  parameter int HYST       = 4
) (
  input logic clock,
  input logic reset_n,
  als_level_averager_if.slave bus
);

  localparam int DIV    = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W  = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
  localparam int RING_N = 1 << PTR_W;
  localparam int SUM_W  = 8 + LOG2_DEPTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] tickCnt_q, tickCnt_d;
  logic [7:0]       ring_q [RING_N];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             upd_q;
  logic [7:0]       avg_q, avg_d;
  logic             avgValid_q;
  logic [3:0]       c_q, c_d;
  logic [7:0]       level_q, level_d;

  logic       tick;
  logic       sampleEn;
  logic [7:0] newSample;
  logic [7:0] oldSample;
  logic [3:0] upN;
  logic [3:0] dnN;
  logic       unusedValueBits;

  assign tick            = (tickCnt_q == LAST_CNT);
  assign sampleEn        = tick && !bus.hold;
  assign newSample       = bus.value[12:5];
  assign oldSample       = ring_q[wrPtr_q];
  assign unusedValueBits = ^{bus.value[15:13], bus.value[4:0]};

  always_comb begin
    tickCnt_d = tick ? '0 : tickCnt_q + CNT_W'(1);
    wrPtr_d   = wrPtr_q;
    sum_d     = sum_q;
    avg_d     = avg_q;
    if (sampleEn) begin
      wrPtr_d = (LOG2_DEPTH == 0) ? '0 : wrPtr_q + PTR_W'(1);
      // Modular arithmetic: the intermediate may wrap but the result always fits.
      sum_d   = sum_q + SUM_W'(newSample) - SUM_W'(oldSample);
    end
    if (upd_q) begin
      avg_d = 8'(sum_q >> LOG2_DEPTH);
    end
  end

  always_comb begin
    upN = '0;
    dnN = '0;
    for (int k = 1; k <= 8; k++) begin
      if ({1'b0, avg_q} >= 9'(32 * k - 16 + HYST)) upN = upN + 4'd1;
      if ({1'b0, avg_q} >= 9'(32 * k - 16 - HYST)) dnN = dnN + 4'd1;
    end
    c_d = c_q;
    if (avgValid_q) begin
      if (c_q < upN) begin
        c_d = upN;
      end else if (c_q > dnN) begin
        c_d = dnN;
      end
    end
    level_d = ~(8'hFF >> c_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tickCnt_q <= '0;
      wrPtr_q   <= '0;
      sum_q     <= '0;
      upd_q     <= 1'b0;
      for (int i = 0; i < RING_N; i++) begin
        ring_q[i] <= '0;
      end
    end else begin
      tickCnt_q <= tickCnt_d;
      wrPtr_q   <= wrPtr_d;
      sum_q     <= sum_d;
      upd_q     <= sampleEn;
      if (sampleEn) begin
        ring_q[wrPtr_q] <= newSample;
      end
    end
  end

  // Output and bar stages trail the sample by one and two cycles respectively.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      avg_q      <= '0;
      avgValid_q <= 1'b0;
      c_q        <= '0;
      level_q    <= 8'h00;
    end else begin
      avg_q      <= avg_d;
      avgValid_q <= upd_q;
      c_q        <= c_d;
      level_q    <= level_d;
    end
  end

  assign bus.avg       = avg_q;
  assign bus.avg_valid = avgValid_q;
  assign bus.level     = level_q;

endmodule
